scsi_cb_decode: RTL
===================

# scsi_cb_decode

Decodes the SCSI command block (CB) byte stream from the BOT CBW parser into fields for the SCSI executor. Captures opcode, LBA and transfer length. Drives the BOT-facing `scsi_busy_o` and `scsi_done_o` status for each command. Sits between the Bulk-Only Transport front end and the block-storage executor.

## Interface
Parameters:
- `CB_MAX`, 16: maximum CB bytes captured; later bytes are discarded and flagged.
- `LEN_WIDTH`, 16: width of `cmd_len_o`.

Ports:
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset.
- `enable_i`  in  1  decoder enable; low is equivalent to reset.
- `cb_tvalid_i`  in  1  CB stream valid (AXI-S).
- `cb_tready_o`  out  1  CB stream ready.
- `cb_tlast_i`  in  1  last CB byte.
- `cb_tdata_i`  in  8  CB byte, CDB byte 0 first.
- `cmd_vld_o`  out  1  decoded command valid; held until `cmd_ack_i`.
- `cmd_ack_i`  in  1  executor accepts the command.
- `cmd_op_o`  out  8  opcode (CDB byte 0).
- `cmd_lba_o`  out  32  LBA, big-endian from CDB bytes 2..5.
- `cmd_len_o`  out  LEN_WIDTH  transfer length, in blocks or bytes depending on opcode.
- `cmd_dir_o`  out  1  1 = device-to-host data phase.
- `cmd_done_i`  in  1  executor finished the command; single-cycle pulse.
- `status_o`  out  1  0 = pass, 1 = fail; valid from the `scsi_done_o` pulse until the next CB byte.
- `scsi_busy_o`  out  1  command in progress.
- `scsi_done_o`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RECV, VALID, EXEC, DONE.
- **IDLE**
  - `cb_tready_o = 1`.
  - First accepted byte: store it as the opcode, set byte count = 1, clear `status_o`, go to RECV. If that byte also has `tlast`, go directly to the end-of-CB check.
- **RECV**
  - `cb_tready_o = 1`.
  - Byte n (n < CB_MAX) is stored at index n.
  - Bytes at n ≥ CB_MAX are accepted and dropped, and set the overflow flag.
  - Byte count is 5 bits and saturates at 16.
- **End of CB** (accepted beat with `tlast`):
  - If count < 6, overflow is set, or the opcode is unsupported: go to DONE with fail.
  - Otherwise decode the fields and go to VALID.
- **Field decoding**
  - READ(10) 0x28: LBA from bytes 2..5; `len` = {b7,b8}; `dir` = 1. Count must be ≥ 10, otherwise fail.
  - WRITE(10) 0x2A: same fields as READ(10); `dir` = 0.
  - INQUIRY 0x12, REQUEST SENSE 0x03, MODE SENSE(6) 0x1A: `len` = b4 (zero-extended); `dir` = 1; LBA = 0.
  - READ CAPACITY(10) 0x25: `len` = 8; `dir` = 1.
  - TEST UNIT READY 0x00: `len` = 0; `dir` = 0.
- **VALID**
  - `cmd_vld_o = 1`; all `cmd_*` fields stable.
  - On `cmd_ack_i`, go to EXEC.
  - If `cmd_ack_i` and `cmd_done_i` arrive in the same cycle, go to DONE with pass.
- **EXEC**
  - Wait for `cmd_done_i`, then go to DONE with pass.
- **DONE**
  - `scsi_done_o = 1` for exactly one cycle, then return to IDLE.
- `scsi_busy_o` is high from the cycle after the first accepted CB byte through the DONE cycle inclusive.
- `cmd_done_i` outside VALID and EXEC is ignored.
- Reset, or `enable_i` low, in any state:
  - Go to IDLE.
  - Clear the count, flags and fields.
  - Abort any in-flight command without a done pulse.

## Timing
- Reset values: `cb_tready_o` = 0 during reset, 1 in IDLE once out of reset. All other outputs are 0 (`cmd_op_o`, `cmd_lba_o`, `cmd_len_o`, `cmd_dir_o`, `cmd_vld_o`, `status_o`, `scsi_busy_o`, `scsi_done_o`).
- `cmd_vld_o` rises on the cycle after the `tlast` beat is accepted (1-cycle latency).
- On a fail path, `scsi_done_o` rises on the cycle after the `tlast` beat is accepted.
- `scsi_done_o` rises on the cycle after the `cmd_done_i` sample.
- `cb_tready_o` is low in VALID, EXEC and DONE. The upstream stalls there; no bytes are lost.
- AXI-S rules:
  - A beat transfers only when `tvalid && tready`.
  - `cmd_vld_o`, once high, does not drop until it is acked.

## Configuration
- `SCSI_CB_WRITE_EN` defined: WRITE(10) 0x2A is decoded as above.
- `SCSI_CB_WRITE_EN` undefined: 0x2A is unsupported and goes to DONE with `status_o = 1`; `cmd_vld_o` never asserts for it.

## Test plan
- READ(10) CB `28 00 00 00 12 34 00 00 08 00` (10 bytes, `tlast` on the last) -> `cmd_vld_o` the next cycle with op = 0x28, LBA = 0x00001234, len = 8, dir = 1. Then ack plus a later `cmd_done_i` -> one `scsi_done_o` pulse with `status_o = 0`. `scsi_busy_o` stays high throughout.
- INQUIRY `12 00 00 00 24 00` -> len = 0x24, dir = 1. `cmd_ack_i` and `cmd_done_i` in the same cycle -> done pulse on the next cycle.
- Unsupported opcode `FF` plus 5 bytes -> no `cmd_vld_o`; `scsi_done_o` pulse with `status_o = 1`.
- 4-byte CB, and separately a 20-byte CB -> both fail. All 20 bytes are accepted; `cb_tready_o` never drops mid-CB.
- WRITE(10) `2A 00 00 00 00 10 00 00 01 00` -> with the macro: dir = 0, LBA = 0x10, len = 1. Without the macro: fail pulse.
- Reset (`reset = 0`) asserted during EXEC -> all outputs 0 the next cycle; no done pulse; the next CB decodes normally.

Source files
------------

// File: rtl/scsi_cb_decode.sv
// scsi_cb_decode
//   Decodes the SCSI command block (CDB) byte stream delivered by the BOT CBW
//   parser into opcode / LBA / transfer length / direction for the executor,
//   and produces the per-command busy / done / status handshake toward BOT.
//
// Parameters
//   CB_MAX     maximum CB bytes counted; later bytes are accepted, dropped and
//              flag the CB as overflowed
//   LEN_WIDTH  width of cmd_len_o
//
// Ports
//   clock, reset (sync, active low), enable_i (low acts as reset)
//   cb_tvalid_i / cb_tready_o / cb_tlast_i / cb_tdata_i : CB byte stream (AXI-S)
//   cmd_vld_o / cmd_ack_i  : decoded command handshake, held until ack
//   cmd_op_o, cmd_lba_o, cmd_len_o, cmd_dir_o : decoded fields (dir 1 = to host)
//   cmd_done_i             : executor completion pulse
//   status_o               : 0 pass / 1 fail, valid from scsi_done_o pulse
//   scsi_busy_o            : command in progress
//   scsi_done_o            : one-cycle completion pulse
//
// Build option
//   SCSI_CB_WRITE_EN : when defined WRITE(10) 0x2A is decoded; otherwise it is
//                      treated as an unsupported opcode and fails.
module scsi_cb_decode #(
  parameter int CB_MAX    = 16,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 cb_tvalid_i,
  output logic                 cb_tready_o,
  input  logic                 cb_tlast_i,
  input  logic [7:0]           cb_tdata_i,
  output logic                 cmd_vld_o,
  input  logic                 cmd_ack_i,
  output logic [7:0]           cmd_op_o,
  output logic [31:0]          cmd_lba_o,
  output logic [LEN_WIDTH-1:0] cmd_len_o,
  output logic                 cmd_dir_o,
  input  logic                 cmd_done_i,
  output logic                 status_o,
  output logic                 scsi_busy_o,
  output logic                 scsi_done_o
);

  localparam int CW = $clog2(CB_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_VALID, S_EXEC, S_DONE} state_t;

  state_t state, state_nxt;

  logic                 run, idle, beat, end_cb, fail, sup;
  logic [CW-1:0]        cnt, idx, cnt_cur, need;
  logic                 ovf, ovf_cur;
  // Only the CDB bytes that feed a decoded field are kept.
  logic [7:0]           b0, b2, b3, b4, b5, b7, b8;
  logic [7:0]           c0, c2, c3, c4, c5, c7, c8;
  logic [31:0]          lba_d;
  logic [LEN_WIDTH-1:0] len_d;
  logic                 dir_d;

  assign run         = reset & enable_i;
  assign idle        = (state == S_IDLE);
  assign cb_tready_o = run & (idle | (state == S_RECV));
  assign beat        = cb_tvalid_i & cb_tready_o;
  assign end_cb      = beat & cb_tlast_i;
  assign cmd_vld_o   = run & (state == S_VALID);
  assign scsi_busy_o = run & ~idle;
  assign scsi_done_o = run & (state == S_DONE);

  // View of the CB including the byte on the bus this cycle. In IDLE the
  // previous command's bytes are masked so a new CB starts from zero.
  always_comb begin
    idx     = idle ? '0 : cnt;
    cnt_cur = (idx >= CW'(CB_MAX)) ? idx : idx + CW'(1);
    ovf_cur = (~idle & ovf) | (idx >= CW'(CB_MAX));
    c0 = (idx == CW'(0)) ? cb_tdata_i : (idle ? 8'h00 : b0);
    c2 = (idx == CW'(2)) ? cb_tdata_i : (idle ? 8'h00 : b2);
    c3 = (idx == CW'(3)) ? cb_tdata_i : (idle ? 8'h00 : b3);
    c4 = (idx == CW'(4)) ? cb_tdata_i : (idle ? 8'h00 : b4);
    c5 = (idx == CW'(5)) ? cb_tdata_i : (idle ? 8'h00 : b5);
    c7 = (idx == CW'(7)) ? cb_tdata_i : (idle ? 8'h00 : b7);
    c8 = (idx == CW'(8)) ? cb_tdata_i : (idle ? 8'h00 : b8);
  end

  // Opcode decode on the completed CB.
  always_comb begin
    sup   = 1'b1;
    need  = CW'(6);
    lba_d = '0;
    len_d = '0;
    dir_d = 1'b0;
    case (c0)
      8'h28: begin
        lba_d = {c2, c3, c4, c5};
        len_d = LEN_WIDTH'({c7, c8});
        dir_d = 1'b1;
        need  = CW'(10);
      end
`ifdef SCSI_CB_WRITE_EN
      8'h2A: begin
        lba_d = {c2, c3, c4, c5};
        len_d = LEN_WIDTH'({c7, c8});
        dir_d = 1'b0;
        need  = CW'(10);
      end
`endif
      8'h12, 8'h03, 8'h1A: begin
        len_d = LEN_WIDTH'(c4);
        dir_d = 1'b1;
      end
      8'h25: begin
        len_d = LEN_WIDTH'(8);
        dir_d = 1'b1;
      end
      8'h00: ;
      default: sup = 1'b0;
    endcase
    fail = (cnt_cur < CW'(6)) | ovf_cur | ~sup | (cnt_cur < need);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RECV: begin
        if (end_cb)    state_nxt = fail ? S_DONE : S_VALID;
        else if (beat) state_nxt = S_RECV;
      end
      S_VALID: if (cmd_ack_i) state_nxt = cmd_done_i ? S_DONE : S_EXEC;
      S_EXEC:  if (cmd_done_i) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!run) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ovf       <= 1'b0;
      b0 <= '0; b2 <= '0; b3 <= '0; b4 <= '0; b5 <= '0; b7 <= '0; b8 <= '0;
      cmd_op_o  <= '0;
      cmd_lba_o <= '0;
      cmd_len_o <= '0;
      cmd_dir_o <= 1'b0;
      status_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (beat) begin
        cnt <= cnt_cur;
        ovf <= ovf_cur;
        b0 <= c0; b2 <= c2; b3 <= c3; b4 <= c4; b5 <= c5; b7 <= c7; b8 <= c8;
        if (idle) status_o <= 1'b0;
      end
      if (end_cb) begin
        if (fail) begin
          status_o <= 1'b1;
        end else begin
          cmd_op_o  <= c0;
          cmd_lba_o <= lba_d;
          cmd_len_o <= len_d;
          cmd_dir_o <= dir_d;
        end
      end
    end
  end

endmodule
